// File: rtl/pcileech_ft601_emu_pkg.sv
// Shared types for the FT601 chip-side emulator: bus phase and sticky error bit positions.
package pcileech_ft601_emu_pkg;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_READ  = 2'd1,
        PH_WRITE = 2'd2
    } phase_t;

    localparam int ERR_RD_UNDERFLOW = 0;
    localparam int ERR_WR_OVERFLOW  = 1;
    localparam int ERR_CONTENTION   = 2;
    localparam int ERR_RD_NO_OE     = 3;

endpackage

// File: rtl/pcileech_ft601_emu_fifo.sv
// Synchronous show-ahead FIFO; head reads as zero when empty, push on full is accepted only alongside a pop.
module pcileech_ft601_emu_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   free,
    output logic [DEPTH_LOG2:0]   count_next,
    output logic [DEPTH_LOG2:0]   free_next
);

    localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem_r [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign empty     = (count_r == {(DEPTH_LOG2+1){1'b0}});
    assign full      = (count_r == DEPTH);
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign count     = count_r;
    assign free      = DEPTH - count_r;
    assign free_next = DEPTH - count_next;

    // Occupancy after the coming edge, used for registered flags upstream.
    always_comb begin
        count_next = count_r;
        if (flush) begin
            count_next = {(DEPTH_LOG2+1){1'b0}};
        end else if (push_ok_s && !pop_ok_s) begin
            count_next = count_r + CNT_ONE;
        end else if (!push_ok_s && pop_ok_s) begin
            count_next = count_r - CNT_ONE;
        end else begin
            count_next = count_r;
        end
    end

    // Storage array; contents are don't-care outside the valid window so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {(DEPTH_LOG2+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next;
        end
    end

endmodule

// File: rtl/pcileech_ft601_emu.sv
// FT601 chip-side responder for the 245 synchronous FIFO bus: host streams on one side, FPGA master strobes on the other.
module pcileech_ft601_emu
    import pcileech_ft601_emu_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 10,
    parameter int TX_DEPTH_LOG2 = 10,
    parameter int TXE_MARGIN    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] host_tx_data,
    input  logic        host_tx_valid,
    output logic        host_tx_ready,
    output logic [31:0] host_rx_data,
    output logic [3:0]  host_rx_be,
    output logic        host_rx_valid,
    input  logic        host_rx_ready,
    input  logic [31:0] ft601_data_in,
    output logic [31:0] ft601_data_out,
    output logic        ft601_data_oe,
    input  logic [3:0]  ft601_be_in,
    output logic [3:0]  ft601_be_out,
    output logic        ft601_rxf_n,
    output logic        ft601_txe_n,
    input  logic        ft601_rd_n,
    input  logic        ft601_oe_n,
    input  logic        ft601_wr_n,
    input  logic        ft601_siwu_n,
    input  logic        ft601_rst_n,
    output logic [3:0]  err_flags,
    output logic [31:0] cnt_rd,
    output logic [31:0] cnt_wr
);

    localparam logic [TX_DEPTH_LOG2:0] TXE_LIM = TXE_MARGIN[TX_DEPTH_LOG2:0];

    phase_t                 phase_r;
    logic                   oe_n_q_r;
    logic                   rxf_n_r;
    logic                   txe_n_r;
    logic [3:0]             err_r;
    logic [31:0]            cnt_rd_r;
    logic [31:0]            cnt_wr_r;

    logic                   flush_s;
    logic                   contention_s;
    logic                   rd_req_s;
    logic                   wr_req_s;
    logic                   rx_push_s;
    logic                   rx_pop_s;
    logic                   tx_push_s;
    logic                   tx_pop_s;
    logic [31:0]            rx_head_s;
    logic                   rx_empty_s;
    logic                   rx_full_s;
    logic [RX_DEPTH_LOG2:0] rx_count_s;
    logic [RX_DEPTH_LOG2:0] rx_free_s;
    logic [RX_DEPTH_LOG2:0] rx_count_next_s;
    logic [RX_DEPTH_LOG2:0] rx_free_next_s;
    logic [35:0]            tx_head_s;
    logic                   tx_empty_s;
    logic                   tx_full_s;
    logic [TX_DEPTH_LOG2:0] tx_count_s;
    logic [TX_DEPTH_LOG2:0] tx_free_s;
    logic [TX_DEPTH_LOG2:0] tx_count_next_s;
    logic [TX_DEPTH_LOG2:0] tx_free_next_s;
    logic                   unused_s;

    // Contending strobes block both directions for that cycle; a chip reset blocks everything.
    assign flush_s      = ~ft601_rst_n;
    assign contention_s = ~ft601_oe_n & ~ft601_wr_n;
    assign rd_req_s     = ft601_rst_n & ~ft601_oe_n & ~ft601_rd_n & ~contention_s;
    assign wr_req_s     = ft601_rst_n & ~ft601_wr_n & ~contention_s;
    assign rx_push_s    = host_tx_valid & host_tx_ready;
    assign rx_pop_s     = rd_req_s & ~rx_empty_s;
    assign tx_pop_s     = host_rx_valid & host_rx_ready;
    assign tx_push_s    = wr_req_s & (~tx_full_s | tx_pop_s);

    pcileech_ft601_emu_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_s),
        .push       (rx_push_s),
        .push_data  (host_tx_data),
        .pop        (rx_pop_s),
        .head       (rx_head_s),
        .empty      (rx_empty_s),
        .full       (rx_full_s),
        .count      (rx_count_s),
        .free       (rx_free_s),
        .count_next (rx_count_next_s),
        .free_next  (rx_free_next_s)
    );

    pcileech_ft601_emu_fifo #(
        .WIDTH      (36),
        .DEPTH_LOG2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_s),
        .push       (tx_push_s),
        .push_data  ({ft601_be_in, ft601_data_in}),
        .pop        (tx_pop_s),
        .head       (tx_head_s),
        .empty      (tx_empty_s),
        .full       (tx_full_s),
        .count      (tx_count_s),
        .free       (tx_free_s),
        .count_next (tx_count_next_s),
        .free_next  (tx_free_next_s)
    );

    assign host_tx_ready  = ~rx_full_s;
    assign host_rx_valid  = ~tx_empty_s;
    assign host_rx_data   = tx_head_s[31:0];
    assign host_rx_be     = tx_head_s[35:32];
    assign ft601_data_out = rx_head_s;
    assign ft601_data_oe  = ~ft601_oe_n & rst_n;
    assign ft601_be_out   = ft601_data_oe ? 4'hF : 4'h0;
    assign ft601_rxf_n    = rxf_n_r;
    assign ft601_txe_n    = txe_n_r;
    assign err_flags      = err_r;
    assign cnt_rd         = cnt_rd_r;
    assign cnt_wr         = cnt_wr_r;
    assign unused_s       = ^{ft601_siwu_n, phase_r, rx_count_s, rx_free_s, rx_free_next_s,
                              tx_count_s, tx_free_s, tx_count_next_s};

    // Bus phase tracker, kept for protocol observation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PH_IDLE;
        end else if (flush_s) begin
            phase_r <= PH_IDLE;
        end else begin
            case (phase_r)
                PH_IDLE: begin
                    if (!ft601_oe_n) begin
                        phase_r <= PH_READ;
                    end else if (!ft601_wr_n) begin
                        phase_r <= PH_WRITE;
                    end else begin
                        phase_r <= PH_IDLE;
                    end
                end
                PH_READ:  phase_r <= ft601_oe_n ? PH_IDLE : PH_READ;
                PH_WRITE: phase_r <= ft601_wr_n ? PH_IDLE : PH_WRITE;
                default:  phase_r <= PH_IDLE;
            endcase
        end
    end

    // Registered bus flags: they describe FIFO state after the current edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxf_n_r  <= 1'b1;
            txe_n_r  <= 1'b1;
            oe_n_q_r <= 1'b1;
        end else begin
            rxf_n_r  <= (rx_count_next_s == {(RX_DEPTH_LOG2+1){1'b0}});
            txe_n_r  <= (tx_free_next_s < TXE_LIM);
            oe_n_q_r <= ft601_oe_n;
        end
    end

    // Sticky errors and transfer counters survive a chip-side flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r    <= 4'h0;
            cnt_rd_r <= 32'd0;
            cnt_wr_r <= 32'd0;
        end else begin
            if (rd_req_s && rx_empty_s) begin
                err_r[ERR_RD_UNDERFLOW] <= 1'b1;
            end
            if (wr_req_s && tx_full_s && !tx_pop_s) begin
                err_r[ERR_WR_OVERFLOW] <= 1'b1;
            end
            if (ft601_rst_n && contention_s) begin
                err_r[ERR_CONTENTION] <= 1'b1;
            end
            if (ft601_rst_n && !ft601_rd_n && oe_n_q_r) begin
                err_r[ERR_RD_NO_OE] <= 1'b1;
            end
            if (rx_pop_s) begin
                cnt_rd_r <= cnt_rd_r + 32'd1;
            end
            if (tx_push_s) begin
                cnt_wr_r <= cnt_wr_r + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pcileech_ft601_emu.sv
// Scoreboard bench for the FT601 emulator: host/FPGA reads, TX overflow, contention, flush and async reset.
module tb_pcileech_ft601_emu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] host_tx_data;
    logic        host_tx_valid;
    logic        host_tx_ready;
    logic [31:0] host_rx_data;
    logic [3:0]  host_rx_be;
    logic        host_rx_valid;
    logic        host_rx_ready;
    logic [31:0] ft601_data_in;
    logic [31:0] ft601_data_out;
    logic        ft601_data_oe;
    logic [3:0]  ft601_be_in;
    logic [3:0]  ft601_be_out;
    logic        ft601_rxf_n;
    logic        ft601_txe_n;
    logic        ft601_rd_n;
    logic        ft601_oe_n;
    logic        ft601_wr_n;
    logic        ft601_siwu_n;
    logic        ft601_rst_n;
    logic [3:0]  err_flags;
    logic [31:0] cnt_rd;
    logic [31:0] cnt_wr;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] rx_q[$];
    logic [35:0] tx_q[$];

    pcileech_ft601_emu #(
        .RX_DEPTH_LOG2 (10),
        .TX_DEPTH_LOG2 (3),
        .TXE_MARGIN    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_tx_data   (host_tx_data),
        .host_tx_valid  (host_tx_valid),
        .host_tx_ready  (host_tx_ready),
        .host_rx_data   (host_rx_data),
        .host_rx_be     (host_rx_be),
        .host_rx_valid  (host_rx_valid),
        .host_rx_ready  (host_rx_ready),
        .ft601_data_in  (ft601_data_in),
        .ft601_data_out (ft601_data_out),
        .ft601_data_oe  (ft601_data_oe),
        .ft601_be_in    (ft601_be_in),
        .ft601_be_out   (ft601_be_out),
        .ft601_rxf_n    (ft601_rxf_n),
        .ft601_txe_n    (ft601_txe_n),
        .ft601_rd_n     (ft601_rd_n),
        .ft601_oe_n     (ft601_oe_n),
        .ft601_wr_n     (ft601_wr_n),
        .ft601_siwu_n   (ft601_siwu_n),
        .ft601_rst_n    (ft601_rst_n),
        .err_flags      (err_flags),
        .cnt_rd         (cnt_rd),
        .cnt_wr         (cnt_wr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_push(input logic [31:0] w);
        host_tx_data  = w;
        host_tx_valid = 1'b1;
        rx_q.push_back(w);
        tick();
        host_tx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_w;
        logic [35:0] exp_t;
        logic [31:0] wdat;
        int          tx_cnt;
        int          n;

        rst_n         = 1'b0;
        host_tx_data  = 32'h0;
        host_tx_valid = 1'b0;
        host_rx_ready = 1'b0;
        ft601_data_in = 32'h0;
        ft601_be_in   = 4'h0;
        ft601_rd_n    = 1'b1;
        ft601_oe_n    = 1'b1;
        ft601_wr_n    = 1'b1;
        ft601_siwu_n  = 1'b1;
        ft601_rst_n   = 1'b1;
        tick();
        tick();
        check_val("rst_rxf_n", ft601_rxf_n, 1'b1);
        check_val("rst_txe_n", ft601_txe_n, 1'b1);
        check_val("rst_oe", ft601_data_oe, 1'b0);
        check_val("rst_err", err_flags, 4'h0);
        check_val("rst_cnt_rd", cnt_rd, 32'd0);
        rst_n = 1'b1;
        tick();
        check_val("idle_rxf_n", ft601_rxf_n, 1'b1);
        check_val("idle_txe_n", ft601_txe_n, 1'b0);

        // Host words 0xA0..0xA2, read by the FPGA
        for (int i = 0; i < 3; i++) begin
            wdat = 32'hA0 + i;
            host_push(wdat);
        end
        check_val("rxf_n_loaded", ft601_rxf_n, 1'b0);
        ft601_oe_n = 1'b0;
        tick();
        check_val("data_oe", ft601_data_oe, 1'b1);
        check_val("be_out", ft601_be_out, 4'hF);
        ft601_rd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_w = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hDEAD;
            check_val("rd_data", ft601_data_out, exp_w);
            if (i == 2) check_val("rxf_n_before_last", ft601_rxf_n, 1'b0);
            tick();
        end
        check_val("rxf_n_after_last", ft601_rxf_n, 1'b1);
        ft601_rd_n = 1'b1;
        ft601_oe_n = 1'b1;
        tick();
        check_val("cnt_rd_3", cnt_rd, 32'd3);
        check_val("err_clean", err_flags, 4'h0);

        // Read from an empty FIFO
        ft601_oe_n = 1'b0;
        tick();
        ft601_rd_n = 1'b0;
        check_val("empty_data", ft601_data_out, 32'h0);
        tick();
        ft601_rd_n = 1'b1;
        ft601_oe_n = 1'b1;
        check_val("err_underflow", err_flags, 4'h1);
        check_val("cnt_rd_held", cnt_rd, 32'd3);
        tick();

        // Ten-word write burst into an 8-deep TX FIFO with the host stalled
        tx_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            wdat          = 32'hB0 + i;
            ft601_data_in = wdat;
            ft601_be_in   = 4'hF;
            ft601_wr_n    = 1'b0;
            if (tx_cnt < 8) begin
                tx_q.push_back({4'hF, wdat});
                tx_cnt++;
            end
            tick();
            check_val("txe_n_burst", ft601_txe_n, ((8 - tx_cnt) < 4) ? 1'b1 : 1'b0);
        end
        ft601_wr_n = 1'b1;
        tick();
        check_val("err_overflow", err_flags, 4'h3);
        check_val("cnt_wr_8", cnt_wr, 32'd8);
        host_rx_ready = 1'b1;
        n = 0;
        while (host_rx_valid && n < 20) begin
            exp_t = (tx_q.size() > 0) ? tx_q.pop_front() : 36'h0;
            check_val("drain_data", host_rx_data, exp_t[31:0]);
            check_val("drain_be", host_rx_be, exp_t[35:32]);
            n++;
            tick();
        end
        host_rx_ready = 1'b0;
        check_val("drain_count", n, 8);
        check_val("txe_n_drained", ft601_txe_n, 1'b0);

        // oe_n and wr_n low together
        host_push(32'hC5);
        ft601_data_in = 32'h55;
        ft601_oe_n    = 1'b0;
        ft601_wr_n    = 1'b0;
        tick();
        ft601_oe_n = 1'b1;
        ft601_wr_n = 1'b1;
        check_val("err_contention", err_flags, 4'h7);
        check_val("cont_cnt_wr", cnt_wr, 32'd8);
        check_val("cont_tx_empty", host_rx_valid, 1'b0);
        check_val("cont_rx_head", ft601_data_out, 32'hC5);
        tick();

        // Chip-side flush with five queued RX words
        for (int i = 0; i < 4; i++) begin
            wdat = 32'hD0 + i;
            host_push(wdat);
        end
        check_val("flush_pre_rxf_n", ft601_rxf_n, 1'b0);
        ft601_rst_n = 1'b0;
        tick();
        ft601_rst_n = 1'b1;
        rx_q.delete();
        check_val("flush_rxf_n", ft601_rxf_n, 1'b1);
        check_val("flush_head", ft601_data_out, 32'h0);
        check_val("flush_cnt_rd", cnt_rd, 32'd3);
        check_val("flush_err", err_flags, 4'h7);
        tick();

        // Async reset in the middle of traffic
        for (int i = 0; i < 3; i++) begin
            host_tx_data  = 32'hE0 + i;
            host_tx_valid = 1'b1;
            ft601_data_in = 32'hF0 + i;
            ft601_wr_n    = 1'b0;
            tick();
        end
        check_val("pre_rst_cnt_wr", cnt_wr, 32'd11);
        #2;
        rst_n         = 1'b0;
        ft601_wr_n    = 1'b1;
        host_tx_valid = 1'b0;
        ft601_oe_n    = 1'b0;
        #1;
        check_val("arst_rxf_n", ft601_rxf_n, 1'b1);
        check_val("arst_txe_n", ft601_txe_n, 1'b1);
        check_val("arst_oe", ft601_data_oe, 1'b0);
        check_val("arst_err", err_flags, 4'h0);
        check_val("arst_cnt_rd", cnt_rd, 32'd0);
        check_val("arst_cnt_wr", cnt_wr, 32'd0);
        check_val("arst_rx_valid", host_rx_valid, 1'b0);
        check_val("arst_data", ft601_data_out, 32'h0);

        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
